rf_wb_arbiter: RTL and testbench

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

---
 rtl/rf_wb_arbiter.sv | 148 ++++++++++++++
 tb/tb_rf_wb_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: round-robin picks up to two of four requesters onto two registered RF write ports and tracks pending writes in a busy scoreboard.
// Latency: grant -> wEN/wAddr/wData one cycle later; a requester not granted stays ungranted (ready low) and retries next cycle; issue stalls on WAW.
module rf_wb_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [3:0]                req_valid,
    output logic [3:0]                req_ready,
    input  logic [4*ADDR_WIDTH-1:0]   req_addr,
    input  logic [4*DATA_WIDTH-1:0]   req_data,
    input  logic                      squash,
    input  logic                      issue_en,
    input  logic [ADDR_WIDTH-1:0]     issue_addr,
    output logic                      issue_stall,
    input  logic [ADDR_WIDTH-1:0]     rs1_addr,
    input  logic [ADDR_WIDTH-1:0]     rs2_addr,
    output logic                      rs1_busy,
    output logic                      rs2_busy,
    output logic                      wEN1,
    output logic [ADDR_WIDTH-1:0]     wAddr1,
    output logic [DATA_WIDTH-1:0]     wData1,
    output logic                      wEN2,
    output logic [ADDR_WIDTH-1:0]     wAddr2,
    output logic [DATA_WIDTH-1:0]     wData2
);
    localparam int NREG = 1 << ADDR_WIDTH;

    logic [1:0]            ptr_q, ptr_d;
    logic [NREG-1:0]       busy_q, busy_d;
    logic                  slot1_vld_q, slot1_vld_d, slot2_vld_q, slot2_vld_d;
    logic                  wen1_q, wen1_d, wen2_q, wen2_d;
    logic [ADDR_WIDTH-1:0] waddr1_q, waddr1_d, waddr2_q, waddr2_d;
    logic [DATA_WIDTH-1:0] wdata1_q, wdata1_d, wdata2_q, wdata2_d;

    logic                  found1, found2, grant1, grant2, conflict;
    logic [1:0]            idx1, idx2, scan_idx;
    logic [ADDR_WIDTH-1:0] addr1, addr2;
    logic [DATA_WIDTH-1:0] data1, data2;

    // Scan from ptr: first valid takes port 1, second valid takes port 2.
    always_comb begin
        found1   = 1'b0;
        found2   = 1'b0;
        idx1     = 2'd0;
        idx2     = 2'd0;
        scan_idx = ptr_q;
        for (int k = 0; k < 4; k++) begin
            scan_idx = ptr_q + 2'(k);
            if (req_valid[scan_idx]) begin
                if (!found1) begin
                    found1 = 1'b1;
                    idx1   = scan_idx;
                end else if (!found2) begin
                    found2 = 1'b1;
                    idx2   = scan_idx;
                end
            end
        end
    end

    assign addr1 = req_addr[idx1*ADDR_WIDTH +: ADDR_WIDTH];
    assign addr2 = req_addr[idx2*ADDR_WIDTH +: ADDR_WIDTH];
    assign data1 = req_data[idx1*DATA_WIDTH +: DATA_WIDTH];
    assign data2 = req_data[idx2*DATA_WIDTH +: DATA_WIDTH];

    // Two writes to the same live register in one cycle would race in the RF; defer the second.
    assign conflict = found2 && (addr1 == addr2) && (addr1 != '0);
    assign grant1   = rst_n && found1;
    assign grant2   = rst_n && found2 && !conflict;

    always_comb begin
        req_ready = 4'b0000;
        if (grant1) req_ready[idx1] = 1'b1;
        if (grant2) req_ready[idx2] = 1'b1;
    end

    assign issue_stall = rst_n && issue_en && (issue_addr != '0) && busy_q[issue_addr];
    assign rs1_busy    = busy_q[rs1_addr];
    assign rs2_busy    = busy_q[rs2_addr];

    always_comb begin
        ptr_d       = ptr_q;
        slot1_vld_d = grant1;
        slot2_vld_d = grant2;
        wen1_d      = 1'b0;
        wen2_d      = 1'b0;
        waddr1_d    = waddr1_q;
        waddr2_d    = waddr2_q;
        wdata1_d    = wdata1_q;
        wdata2_d    = wdata2_q;
        if (grant1) begin
            waddr1_d = addr1;
            wdata1_d = data1;
            wen1_d   = (addr1 != '0) && !(squash && idx1 == 2'd0);
            ptr_d    = idx1 + 2'd1;
        end
        if (grant2) begin
            waddr2_d = addr2;
            wdata2_d = data2;
            wen2_d   = (addr2 != '0) && !(squash && idx2 == 2'd0);
            ptr_d    = idx2 + 2'd1;
        end
    end

    // Squashed slots still retire their destination; a new issue on the same edge wins.
    always_comb begin
        busy_d = busy_q;
        if (slot1_vld_q) busy_d[waddr1_q] = 1'b0;
        if (slot2_vld_q) busy_d[waddr2_q] = 1'b0;
        if (issue_en && !issue_stall && issue_addr != '0) busy_d[issue_addr] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q       <= 2'd0;
            busy_q      <= '0;
            slot1_vld_q <= 1'b0;
            slot2_vld_q <= 1'b0;
            wen1_q      <= 1'b0;
            wen2_q      <= 1'b0;
            waddr1_q    <= '0;
            waddr2_q    <= '0;
            wdata1_q    <= '0;
            wdata2_q    <= '0;
        end else begin
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            slot1_vld_q <= slot1_vld_d;
            slot2_vld_q <= slot2_vld_d;
            wen1_q      <= wen1_d;
            wen2_q      <= wen2_d;
            waddr1_q    <= waddr1_d;
            waddr2_q    <= waddr2_d;
            wdata1_q    <= wdata1_d;
            wdata2_q    <= wdata2_d;
        end
    end

    assign wEN1   = wen1_q;
    assign wAddr1 = waddr1_q;
    assign wData1 = wdata1_q;
    assign wEN2   = wen2_q;
    assign wAddr2 = waddr2_q;
    assign wData2 = wdata2_q;
endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: scenario tasks with an expected-write queue checked one cycle after each grant.
module tb_rf_wb_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [3:0]    req_ready;
    logic [4*AW-1:0] req_addr;
    logic [4*DW-1:0] req_data;
    logic          squash, issue_en, issue_stall;
    logic [AW-1:0] issue_addr, rs1_addr, rs2_addr;
    logic          rs1_busy, rs2_busy;
    logic          wEN1, wEN2;
    logic [AW-1:0] wAddr1, wAddr2;
    logic [DW-1:0] wData1, wData2;

    rf_wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .squash(squash),
        .issue_en(issue_en), .issue_addr(issue_addr), .issue_stall(issue_stall),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .wEN1(wEN1), .wAddr1(wAddr1), .wData1(wData1),
        .wEN2(wEN2), .wAddr2(wAddr2), .wData2(wData2)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            port;
        logic          en;
        logic          chk;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_t;

    wb_t           sb[$];
    wb_t           e;
    logic          got_en;
    logic [AW-1:0] got_a;
    logic [DW-1:0] got_d;
    int            checks = 0;
    int            passed = 0;

    function automatic logic [DW-1:0] dat(input int i, input logic [AW-1:0] a);
        return 32'hD000_0000 + 32'(i) * 32'h100 + 32'(a);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic [AW-1:0] a);
        req_addr[i*AW +: AW] = a;
        req_data[i*DW +: DW] = dat(i, a);
    endtask

    task automatic push(input int port, input logic en, input logic chk, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wb_t w;
        w.port = port; w.en = en; w.chk = chk; w.addr = a; w.data = d;
        sb.push_back(w);
    endtask

    task automatic idle_inputs;
        req_valid = 4'b0000; req_addr = '0; req_data = '0; squash = 1'b0;
        issue_en = 1'b0; issue_addr = '0; rs1_addr = '0; rs2_addr = '0;
    endtask

    task automatic apply_reset;
        idle_inputs();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst_n = 1'b0;
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, AW'(i + 1));
        issue_en = 1'b1; issue_addr = 5'd3; rs1_addr = 5'd3;
        #1;
        checks++; if (req_ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", req_ready); else passed++;
        checks++; if (issue_stall !== 1'b0) $display("FAIL reset_stall: got %b want 0", issue_stall); else passed++;
        tick();
        tick();
        checks++; if ({wEN1, wEN2} !== 2'b00) $display("FAIL reset_wen: got %b want 00", {wEN1, wEN2}); else passed++;
        checks++; if ({wAddr1, wAddr2, wData1, wData2} !== '0) $display("FAIL reset_wbus: got %h/%h/%h/%h want zeros", wAddr1, wAddr2, wData1, wData2); else passed++;
        checks++; if (rs1_busy !== 1'b0) $display("FAIL reset_busy: got %b want 0 (issue ignored in reset)", rs1_busy); else passed++;
        idle_inputs();
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000) $display("FAIL idle_ready: got %b want 0000", req_ready); else passed++;
    endtask

    task automatic test_dual_grant;
        apply_reset();
        req_valid = 4'b0101; set_req(0, 5'd3); set_req(2, 5'd7);
        #1;
        checks++; if (req_ready !== 4'b0101) $display("FAIL dual_ready: got %b want 0101", req_ready); else passed++;
        push(1, 1'b1, 1'b1, 5'd3, dat(0, 5'd3));
        push(2, 1'b1, 1'b1, 5'd7, dat(2, 5'd7));
        tick();
        // Pointer should now be 3: all four valid with distinct addresses -> requesters 3 then 0.
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, AW'(11 + i));
        #1;
        checks++; if (req_ready !== 4'b1001) $display("FAIL ptr3_ready: got %b want 1001", req_ready); else passed++;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port == 1) begin got_en = wEN1; got_a = wAddr1; got_d = wData1; end
            else begin got_en = wEN2; got_a = wAddr2; got_d = wData2; end
            checks++;
            if (got_en !== e.en || (e.chk && (got_a !== e.addr || got_d !== e.data)))
                $display("FAIL dual_wb_p%0d: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", e.port, got_en, got_a, got_d, e.en, e.addr, e.data);
            else passed++;
        end
        push(1, 1'b1, 1'b1, 5'd14, dat(3, 5'd14));
        push(2, 1'b1, 1'b1, 5'd11, dat(0, 5'd11));
        tick();
        req_valid = 4'b0000;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            if (e.port == 1) begin got_en = wEN1; got_a = wAddr1; got_d = wData1; end
            else begin got_en = wEN2; got_a = wAddr2; got_d = wData2; end
            checks++;
            if (got_en !== e.en || (e.chk && (got_a !== e.addr || got_d !== e.data)))
                $display("FAIL wrap_wb_p%0d: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", e.port, got_en, got_a, got_d, e.en, e.addr, e.data);
            else passed++;
        end
    endtask

    task automatic test_round_robin;
        logic [3:0] exp_rdy[3] = '{4'b0011, 4'b1100, 4'b0011};
        int         first[3]   = '{0, 2, 0};
        int         second[3]  = '{1, 3, 1};
        apply_reset();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, AW'(i + 1));
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++; if (req_ready !== exp_rdy[c]) $display("FAIL rr_ready_c%0d: got %b want %b", c, req_ready, exp_rdy[c]); else passed++;
            push(1, 1'b1, 1'b1, AW'(first[c] + 1), dat(first[c], AW'(first[c] + 1)));
            push(2, 1'b1, 1'b1, AW'(second[c] + 1), dat(second[c], AW'(second[c] + 1)));
            tick();
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == 1) begin got_en = wEN1; got_a = wAddr1; got_d = wData1; end
                else begin got_en = wEN2; got_a = wAddr2; got_d = wData2; end
                checks++;
                if (got_en !== e.en || (e.chk && (got_a !== e.addr || got_d !== e.data)))
                    $display("FAIL rr_wb_c%0d_p%0d: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", c, e.port, got_en, got_a, got_d, e.en, e.addr, e.data);
                else passed++;
            end
        end
        req_valid = 4'b0000;
    endtask

    task automatic test_conflict;
        apply_reset();
        req_valid = 4'b1010; set_req(1, 5'd9); set_req(3, 5'd9);
        for (int c = 0; c < 2; c++) begin
            #1;
            if (c == 0) begin
                checks++; if (req_ready !== 4'b0010) $display("FAIL conflict_ready0: got %b want 0010", req_ready); else passed++;
                push(1, 1'b1, 1'b1, 5'd9, dat(1, 5'd9));
            end else begin
                checks++; if (req_ready !== 4'b1000) $display("FAIL conflict_ready1: got %b want 1000", req_ready); else passed++;
                push(1, 1'b1, 1'b1, 5'd9, dat(3, 5'd9));
            end
            push(2, 1'b0, 1'b0, '0, '0);
            tick();
            req_valid = 4'b1000;
            while (sb.size() != 0) begin
                e = sb.pop_front();
                if (e.port == 1) begin got_en = wEN1; got_a = wAddr1; got_d = wData1; end
                else begin got_en = wEN2; got_a = wAddr2; got_d = wData2; end
                checks++;
                if (got_en !== e.en || (e.chk && (got_a !== e.addr || got_d !== e.data)))
                    $display("FAIL conflict_wb_c%0d_p%0d: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", c, e.port, got_en, got_a, got_d, e.en, e.addr, e.data);
                else passed++;
            end
        end
        req_valid = 4'b0000;
        tick();
        checks++; if ({wEN1, wEN2} !== 2'b00) $display("FAIL idle_wen: got %b want 00", {wEN1, wEN2}); else passed++;
        checks++; if (wAddr1 !== 5'd9 || wData1 !== dat(3, 5'd9) || wAddr2 !== 5'd0)
            $display("FAIL hold_wbus: got a1=%0d d1=%h a2=%0d want a1=9 d1=%h a2=0", wAddr1, wData1, wAddr2, dat(3, 5'd9)); else passed++;
    endtask

    task automatic test_scoreboard;
        apply_reset();
        issue_en = 1'b1; issue_addr = 5'd5; rs1_addr = 5'd5;
        #1;
        checks++; if (issue_stall !== 1'b0 || rs1_busy !== 1'b0) $display("FAIL sb_first_issue: got stall=%b busy=%b want 0/0", issue_stall, rs1_busy); else passed++;
        tick();
        #1;
        checks++; if (rs1_busy !== 1'b1 || issue_stall !== 1'b1) $display("FAIL sb_waw: got busy=%b stall=%b want 1/1", rs1_busy, issue_stall); else passed++;
        issue_en = 1'b0;
        req_valid = 4'b0100; set_req(2, 5'd5);
        #1;
        checks++; if (req_ready !== 4'b0100) $display("FAIL sb_ready: got %b want 0100", req_ready); else passed++;
        push(1, 1'b1, 1'b1, 5'd5, dat(2, 5'd5));
        tick();
        req_valid = 4'b0000;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            got_en = wEN1; got_a = wAddr1; got_d = wData1;
            checks++;
            if (got_en !== e.en || (e.chk && (got_a !== e.addr || got_d !== e.data)))
                $display("FAIL sb_wb: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", got_en, got_a, got_d, e.en, e.addr, e.data);
            else passed++;
        end
        checks++; if (rs1_busy !== 1'b1) $display("FAIL sb_busy_during_wb: got %b want 1", rs1_busy); else passed++;
        tick();
        checks++; if (rs1_busy !== 1'b0) $display("FAIL sb_busy_cleared: got %b want 0", rs1_busy); else passed++;
        // A fresh issue landing on the same edge as a retiring write to that register must stay busy.
        req_valid = 4'b0001; set_req(0, 5'd8); rs2_addr = 5'd8;
        tick();
        req_valid = 4'b0000;
        issue_en = 1'b1; issue_addr = 5'd8;
        #1;
        checks++; if (issue_stall !== 1'b0) $display("FAIL sb_set_stall: got %b want 0", issue_stall); else passed++;
        tick();
        issue_en = 1'b0;
        checks++; if (rs2_busy !== 1'b1) $display("FAIL sb_set_wins: got %b want 1", rs2_busy); else passed++;
    endtask

    task automatic test_squash_addr0;
        apply_reset();
        issue_en = 1'b1; issue_addr = 5'd6; rs1_addr = 5'd6;
        tick();
        issue_en = 1'b0;
        req_valid = 4'b0001; set_req(0, 5'd6); squash = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0001) $display("FAIL squash_ready: got %b want 0001", req_ready); else passed++;
        push(1, 1'b0, 1'b1, 5'd6, dat(0, 5'd6));
        tick();
        squash = 1'b0;
        req_valid = 4'b1000; set_req(3, 5'd0);
        #1;
        checks++; if (req_ready !== 4'b1000) $display("FAIL addr0_ready: got %b want 1000", req_ready); else passed++;
        checks++; if (rs1_busy !== 1'b1) $display("FAIL squash_busy_pre: got %b want 1", rs1_busy); else passed++;
        push(1, 1'b0, 1'b1, 5'd0, dat(3, 5'd0));
        for (int c = 0; c < 2; c++) begin
            e = sb.pop_front();
            got_en = wEN1; got_a = wAddr1; got_d = wData1;
            checks++;
            if (got_en !== e.en || (e.chk && (got_a !== e.addr || got_d !== e.data)))
                $display("FAIL squash_wb_%0d: got en=%b addr=%0d data=%h want en=%b addr=%0d data=%h", c, got_en, got_a, got_d, e.en, e.addr, e.data);
            else passed++;
            tick();
            req_valid = 4'b0000;
        end
        checks++; if (rs1_busy !== 1'b0) $display("FAIL squash_busy_cleared: got %b want 0", rs1_busy); else passed++;
    endtask

    task automatic test_reset_mid;
        apply_reset();
        issue_en = 1'b1; issue_addr = 5'd10; rs1_addr = 5'd10;
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_req(i, AW'(20 + i));
        rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000 || issue_stall !== 1'b0) $display("FAIL midrst_comb: got ready=%b stall=%b want 0000/0", req_ready, issue_stall); else passed++;
        tick();
        checks++; if ({wEN1, wEN2} !== 2'b00 || {wAddr1, wAddr2, wData1, wData2} !== '0)
            $display("FAIL midrst_wb: got en=%b%b a=%0d/%0d d=%h/%h want zeros", wEN1, wEN2, wAddr1, wAddr2, wData1, wData2); else passed++;
        checks++; if (rs1_busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", rs1_busy); else passed++;
        issue_en = 1'b0;
        rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0011) $display("FAIL postrst_ready: got %b want 0011", req_ready); else passed++;
        req_valid = 4'b0000;
        tick();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_dual_grant();
        test_round_robin();
        test_conflict();
        test_scoreboard();
        test_squash_addr0();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
